display_scan_mux: RTL
=====================

Name: display_scan_mux

Overview:
- Time-multiplexes four BCD digits of the watch time/date onto one shared 7-segment decoder.
- Each scan slot drives the current digit's BCD code to the downstream BCD-to-segment decoder and asserts that digit's common-anode enable.
- Provides per-digit forced blanking, per-digit blink, leading-zero suppression and decimal-point control.
- Sits between the timekeeping counters and the segment decoder/board pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (>=2)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
digit0  input  4  least-significant BCD digit (rightmost)
digit1  input  4  BCD digit 1
digit2  input  4  BCD digit 2
digit3  input  4  most-significant BCD digit (leftmost)
blank_mask  input  4  bit i=1 forces digit i dark
blink_mask  input  4  bit i=1 blanks digit i while blink phase is high
dp_mask  input  4  bit i=1 lights the decimal point on digit i
lz_en  input  1  enable leading-zero suppression
bcd_out  output  4  BCD code to the segment decoder; 4'hF means blank
an  output  4  active-low digit anode enables; one-hot-low or all ones
dp_n  output  1  active-low decimal point
frame_start  output  1  one-cycle pulse when the scan returns to digit 0

Behaviour:
Reset:
- While reset is high: prescaler=SCAN_DIV-1, idx=3, blink counter=0, blink_phase=0, snapshot regs=0.
- Outputs during reset: an=4'b1111, bcd_out=4'hF, dp_n=1, frame_start=0.
- Reset asserted mid-scan takes effect at the next edge and overrides everything.

Prescaler and slot index:
- Prescaler counts up to SCAN_DIV-1, then wraps to 0.
- tick=1 in the cycle where prescaler==SCAN_DIV-1.
- On tick, idx advances 0->1->2->3->0 (2-bit wrap).

Snapshot:
- On a tick with idx==3 (frame wrap), digit0..3, blank_mask, blink_mask, dp_mask and lz_en are captured into snapshot regs.
- All display logic uses snapshot values only, so a frame is always coherent.
- Input changes mid-frame appear only from the next frame.

First frame after reset:
- The first edge after reset deassertion is a tick with frame wrap.
- That edge loads the snapshot, sets idx=0 and pulses frame_start.

Blink:
- Blink counter counts 0..BLINK_DIV-1 and wraps.
- blink_phase toggles on each wrap.
- The blink counter is free-running and independent of the scan.

Blank condition for slot i (from snapshot):
- blank_mask[i], OR
- (blink_mask[i] AND blink_phase), OR
- (lz_en AND i>0 AND digits i..3 all zero).
- Digit 0 is never zero-suppressed. A value of 0000 therefore shows a single "0".

Outputs (registered, one-cycle latency from the idx/snapshot/blink_phase state):
- Not blanked: an = all ones except bit idx = 0; bcd_out = snapshot digit[idx].
- Blanked: an=4'b1111, bcd_out=4'hF.
- dp_n = ~(dp_mask[idx] AND not blanked).
- Non-BCD input values (10..15) are passed through unmodified; the decoder renders them dark, and the anode remains asserted.

frame_start:
- High for exactly the one cycle in which the outputs first show slot 0 of a new frame.
- That is, one cycle after the wrap tick.

Invariants:
- an is never more than one bit low.
- Exactly SCAN_DIV cycles per slot and 4*SCAN_DIV cycles per frame in steady state.

Simultaneous events:
- Blink wrap coinciding with a scan tick: both apply on the same edge.
- The new blink_phase affects outputs from the next registered update.

Test Plan:
(All with SCAN_DIV=4, BLINK_DIV=32.)
1. Reset then release; digits 3,2,1,0 = 1,2,3,4.
   - Required: cycle 2 after release shows an=1110, bcd_out=4, frame_start=1.
   - Slots change every 4 cycles to an=1101/bcd=3, 1011/2, 0111/1, then back to 1110.
2. Digits=0,0,0,7 (d3..d0), lz_en=1.
   - Required: slots 1-3 give an=1111, bcd_out=F; slot 0 gives an=1110, bcd_out=7.
   - Digits all 0: only digit 0 lit, showing 0.
   - lz_en=0: all four lit showing 0.
3. blink_mask=4'b0011, digits=5,9,4,2, for 128 cycles.
   - Required: digits 1,0 dark during blink_phase=1 windows (32 cycles each) and lit otherwise.
   - Digits 3,2 are always lit.
4. Change digit2 from 4 to 8 while idx==1.
   - Required: slot 2 of the current frame still shows 4; the next frame shows 8.
   - Masks changed mid-frame follow the same rule.
5. dp_mask=4'b0100 combined with blank_mask=4'b0100.
   - Required: dp_n=1 in every slot.
   - With blank_mask=0: dp_n=0 only while an=1011.
6. Assert reset for 1 cycle mid-slot 2.
   - Required: next cycle an=1111, bcd_out=F, dp_n=1.
   - After release, the scan restarts at slot 0 per scenario 1 timing.
   - Across the whole run, an is never more than one bit low.

Source files
------------

// File: rtl/display_scan_mux.sv
// ============================================================================
// Module      : display_scan_mux
// Description : Scans four BCD digits onto one shared 7-segment decoder with
//               blanking, blink, leading-zero suppression and decimal points.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] blank_mask,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  input  logic       lz_en,
  output logic [3:0] bcd_out,
  output logic [3:0] an,
  output logic       dp_n,
  output logic       frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic [15:0]   snap_digits;
  logic [3:0]    snap_blank;
  logic [3:0]    snap_blink;
  logic [3:0]    snap_dp;
  logic          snap_lz;
  logic          snap_valid;

  logic          tick;
  logic          wrap;
  logic          blink_wrap;
  logic [3:0]    cur_digit;
  logic          upper_zero;
  logic          blanked;

  assign tick       = (pre == PRE_MAX);
  assign wrap       = tick && (idx == 2'd3);
  assign blink_wrap = (blink_cnt == BLINK_MAX);

  // Scan timing, free-running blink timebase and the per-frame input snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre         <= PRE_MAX;
      idx         <= 2'd3;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_blank  <= '0;
      snap_blink  <= '0;
      snap_dp     <= '0;
      snap_lz     <= 1'b0;
      snap_valid  <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (wrap) begin
        snap_digits <= {digit3, digit2, digit1, digit0};
        snap_blank  <= blank_mask;
        snap_blink  <= blink_mask;
        snap_dp     <= dp_mask;
        snap_lz     <= lz_en;
        snap_valid  <= 1'b1;
      end
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
      if (blink_wrap) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

  always_comb begin
    cur_digit  = snap_digits[idx*4 +: 4];
    upper_zero = 1'b0;
    case (idx)
      2'd1:    upper_zero = (snap_digits[15:4]  == 12'd0);
      2'd2:    upper_zero = (snap_digits[15:8]  == 8'd0);
      2'd3:    upper_zero = (snap_digits[15:12] == 4'd0);
      default: upper_zero = 1'b0;
    endcase
    // Nothing valid to show until the first frame's snapshot has been taken.
    blanked = !snap_valid
           || snap_blank[idx]
           || (snap_blink[idx] && blink_phase)
           || (snap_lz && upper_zero);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= 4'b1111;
      bcd_out     <= 4'hF;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= blanked ? 4'b1111 : ~(4'b0001 << idx);
      bcd_out     <= blanked ? 4'hF : cur_digit;
      dp_n        <= ~(snap_dp[idx] && !blanked);
      frame_start <= (idx == 2'd0) && (pre == '0);
    end
  end

endmodule

`default_nettype wire
